// File: rtl/border_pad.sv
// Surrounds each width x height RGB frame with a one-pixel black border, buffering input in a FIFO.
// Define BORDER_PAD_OVERFLOW_EN to compile in the sticky FIFO-overflow detector on oOverflow.
module border_pad #(
    parameter int width     = 320,
    parameter int height    = 240,
    parameter int fifoDepth = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        newFrame,
    input  logic        iValid,
    input  logic [23:0] iData,
    output logic        oValid,
    output logic [23:0] oData,
    output logic        oDone,
    output logic        oOverflow
);
    localparam int AW   = $clog2(fifoDepth);
    localparam int NPIX = width * height;
    localparam int IW   = $clog2(NPIX + 1);
    localparam int CW   = $clog2(width + 2);
    localparam int RW   = $clog2(height + 1);

    localparam logic [IW-1:0] NPIX_C       = IW'(NPIX);
    localparam logic [IW-1:0] CNT_ONE      = IW'(1);
    localparam logic [CW-1:0] COL_ONE      = CW'(1);
    localparam logic [CW-1:0] COL_PIX_LAST = CW'(width - 1);
    localparam logic [CW-1:0] COL_BRD_LAST = CW'(width + 1);
    localparam logic [RW-1:0] ROW_ONE      = RW'(1);
    localparam logic [RW-1:0] ROW_LAST     = RW'(height - 1);
    localparam logic [AW:0]   PTR_ONE      = (AW + 1)'(1);
    localparam logic [AW:0]   DEPTH_C      = (AW + 1)'(fifoDepth);

    typedef enum logic [2:0] {IDLE, TOP, LEFT, PIX, RIGHT, BOTTOM, DONE} state_t;

    state_t        state_q;
    logic          armed_q;
    logic [IW-1:0] in_cnt_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic [23:0]   fifo_mem [fifoDepth];
    logic          valid_q;
    logic [23:0]   data_q;
    logic          done_q;

    logic [AW:0]   occupancy;
    logic          fifo_empty;
    logic          fifo_full;
    logic          full_eff;
    logic [IW-1:0] cnt_base;
    logic [AW:0]   wr_base;
    logic          wr_try;
    logic          wr_en;
    logic          rd_en;
    logic [23:0]   rd_data;

    // newFrame flushes in the same cycle, so a coincident pixel becomes pixel 0 of the new frame.
    assign occupancy  = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (occupancy == '0);
    assign fifo_full  = (occupancy == DEPTH_C);
    assign cnt_base   = newFrame ? '0 : in_cnt_q;
    assign wr_base    = newFrame ? '0 : wr_ptr_q;
    assign full_eff   = !newFrame && fifo_full;
    assign wr_try     = iValid && (armed_q || newFrame) && (cnt_base < NPIX_C);
    assign wr_en      = wr_try && !full_eff;
    assign rd_en      = (state_q == PIX) && !fifo_empty && !newFrame;
    assign rd_data    = fifo_mem[rd_ptr_q[AW-1:0]];

    // NOTE: the pixel store has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) fifo_mem[wr_base[AW-1:0]] <= iData;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            armed_q  <= 1'b0;
            in_cnt_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            in_cnt_q <= wr_try ? cnt_base + CNT_ONE : cnt_base;
            wr_ptr_q <= wr_en ? wr_base + PTR_ONE : wr_base;
            rd_ptr_q <= newFrame ? '0 : (rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q);
            valid_q  <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            if (newFrame) begin
                // The first top-border zero is emitted on the strobe edge itself.
                state_q <= TOP;
                armed_q <= 1'b1;
                col_q   <= COL_ONE;
                row_q   <= '0;
                valid_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: ;
                    TOP, BOTTOM: begin
                        valid_q <= 1'b1;
                        if (col_q == COL_BRD_LAST) begin
                            col_q   <= '0;
                            state_q <= (state_q == TOP) ? LEFT : DONE;
                        end else begin
                            col_q <= col_q + COL_ONE;
                        end
                    end
                    LEFT: begin
                        valid_q <= 1'b1;
                        state_q <= PIX;
                    end
                    PIX: begin
                        if (rd_en) begin
                            valid_q <= 1'b1;
                            data_q  <= rd_data;
                            if (col_q == COL_PIX_LAST) begin
                                col_q   <= '0;
                                state_q <= RIGHT;
                            end else begin
                                col_q <= col_q + COL_ONE;
                            end
                        end
                    end
                    RIGHT: begin
                        valid_q <= 1'b1;
                        row_q   <= row_q + ROW_ONE;
                        state_q <= (row_q == ROW_LAST) ? BOTTOM : LEFT;
                    end
                    DONE: begin
                        done_q  <= 1'b1;
                        armed_q <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef BORDER_PAD_OVERFLOW_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (reset || newFrame) ovf_q <= 1'b0;
        else if (wr_try && full_eff) ovf_q <= 1'b1;
    end

    assign oOverflow = ovf_q;
`else
    assign oOverflow = 1'b0;
`endif

    assign oValid = valid_q;
    assign oData  = data_q;
    assign oDone  = done_q;
endmodule

// File: tb/tb_border_pad.sv
// Self-checking bench for border_pad: vector table, random frames against a padded-image model,
// plus abort, mid-frame reset and FIFO-overflow sequences.
module tb_border_pad;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int NP = W * H;
    localparam int NOUT = (W + 2) * (H + 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        a_reset = 1'b1;
    logic        a_nf = 1'b0;
    logic        a_iv = 1'b0;
    logic [23:0] a_id = '0;
    logic        a_ov;
    logic [23:0] a_od;
    logic        a_done;
    logic        a_ovf;

    logic        c_reset = 1'b1;
    logic        c_nf = 1'b0;
    logic        c_iv = 1'b0;
    logic [23:0] c_id = '0;
    logic        c_ov;
    logic [23:0] c_od;
    logic        c_done;
    logic        c_ovf;

    border_pad #(.width(W), .height(H), .fifoDepth(8)) u_a (
        .clk(clk), .reset(a_reset), .newFrame(a_nf), .iValid(a_iv), .iData(a_id),
        .oValid(a_ov), .oData(a_od), .oDone(a_done), .oOverflow(a_ovf)
    );

    border_pad #(.width(8), .height(1), .fifoDepth(4)) u_c (
        .clk(clk), .reset(c_reset), .newFrame(c_nf), .iValid(c_iv), .iData(c_id),
        .oValid(c_ov), .oData(c_od), .oDone(c_done), .oOverflow(c_ovf)
    );

    typedef struct {
        string name;
        bit    coincide;
        int    gap_max;
        int    trailing;
        bit    rand_data;
        int    exp_count;
        int    exp_done;
    } vec_t;

    logic [23:0] got_q[$];
    logic [23:0] exp_q[$];
    logic [23:0] pix [NP];
    int done_cnt = 0;
    int neg_idx = 0;
    int first_valid_idx = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (a_ov) got_q.push_back(a_od);
        else check("idle_data_zero", {8'h0, a_od}, 32'h0);
        if (a_done) begin
            done_cnt++;
            check("done_without_valid", {31'h0, a_ov}, 32'h0);
        end
        if (a_ov && first_valid_idx < 0) first_valid_idx = neg_idx;
        neg_idx++;
    end

    // Reference: the input image placed inside a zero frame, read out in raster order.
    task automatic build_expected();
        exp_q.delete();
        for (int r = 0; r < H + 2; r++)
            for (int c = 0; c < W + 2; c++)
                if (r == 0 || r == H + 1 || c == 0 || c == W + 1) exp_q.push_back(24'h0);
                else exp_q.push_back(pix[(r - 1) * W + (c - 1)]);
    endtask

    task automatic run_frame(input string name, input bit coincide, input int gap_max,
                             input int trailing, input int exp_count, input int exp_done);
        build_expected();
        a_nf = 1'b1;
        a_iv = coincide;
        a_id = coincide ? pix[0] : 24'h0;
        @(posedge clk);
        got_q.delete();
        done_cnt = 0;
        neg_idx = 0;
        first_valid_idx = -1;
        #1;
        a_nf = 1'b0;
        a_iv = 1'b0;
        a_id = '0;
        for (int i = (coincide ? 1 : 0); i < NP; i++) begin
            int g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) begin @(posedge clk); #1; end
            a_iv = 1'b1;
            a_id = pix[i];
            @(posedge clk); #1;
            a_iv = 1'b0;
            a_id = '0;
        end
        repeat (trailing) begin
            a_iv = 1'b1;
            a_id = 24'hFFFFFF;
            @(posedge clk); #1;
        end
        a_iv = 1'b0;
        a_id = '0;
        for (int t = 0; t < 400 && done_cnt == 0; t++) @(posedge clk);
        repeat (8) @(posedge clk);
        #1;
        check({name, "_count"}, got_q.size(), exp_count);
        check({name, "_done"}, done_cnt, exp_done);
        check({name, "_first_valid_lat"}, first_valid_idx, 0);
        check({name, "_ovf"}, {31'h0, a_ovf}, 32'h0);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_px%0d", name, i), {8'h0, got_q[i]}, {8'h0, exp_q[i]});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   sz;
        int   d0;
        int   t;
        logic exp_ovf;

        vecs[0] = '{"ref_1to8",   1'b0, 0,  0,  1'b0, NOUT, 1};
        vecs[1] = '{"trail20",    1'b0, 0,  20, 1'b0, NOUT, 1};
        vecs[2] = '{"coincide",   1'b1, 0,  0,  1'b0, NOUT, 1};
        vecs[3] = '{"gaps",       1'b0, 5,  0,  1'b1, NOUT, 1};
        vecs[4] = '{"gaps_trail", 1'b1, 3,  7,  1'b1, NOUT, 1};
        vecs[5] = '{"slow_src",   1'b0, 12, 2,  1'b1, NOUT, 1};

        // Reset wins over a coincident newFrame.
        repeat (2) @(posedge clk);
        #1;
        a_nf = 1'b1;
        @(posedge clk); #1;
        a_nf = 1'b0;
        check("rst_valid", {31'h0, a_ov}, 32'h0);
        check("rst_data", {8'h0, a_od}, 32'h0);
        check("rst_done", {31'h0, a_done}, 32'h0);
        check("rst_ovf", {31'h0, a_ovf}, 32'h0);
        a_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_rst", {31'h0, a_ov}, 32'h0);

        foreach (vecs[k]) begin
            for (int i = 0; i < NP; i++) pix[i] = vecs[k].rand_data ? 24'($urandom) : 24'(i + 1);
            run_frame(vecs[k].name, vecs[k].coincide, vecs[k].gap_max, vecs[k].trailing,
                      vecs[k].exp_count, vecs[k].exp_done);
        end

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NP; i++) pix[i] = 24'($urandom);
            run_frame($sformatf("rand%0d", k), 1'($urandom_range(1, 0)), int'($urandom_range(4, 0)),
                      int'($urandom_range(10, 0)), NOUT, 1);
        end

        // Abort mid-PIX of row 0, then a complete new frame.
        a_nf = 1'b1;
        @(posedge clk); #1;
        a_nf = 1'b0;
        for (int i = 0; i < NP; i++) begin
            a_iv = 1'b1;
            a_id = 24'h00A000 + 24'(i);
            @(posedge clk); #1;
        end
        a_iv = 1'b0;
        a_id = '0;
        for (int i = 0; i < NP; i++) pix[i] = 24'($urandom);
        run_frame("abort_new", 1'b0, 0, 0, NOUT, 1);

        // Reset at output pixel 10, then stray input while disarmed, then a clean frame.
        a_nf = 1'b1;
        @(posedge clk);
        got_q.delete();
        #1;
        a_nf = 1'b0;
        for (int i = 0; i < NP; i++) begin
            a_iv = 1'b1;
            a_id = 24'(i + 1);
            @(posedge clk); #1;
        end
        a_iv = 1'b0;
        t = 0;
        while (got_q.size() < 10 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("rst_reach_px10", {31'h0, got_q.size() >= 10}, 32'h1);
        a_reset = 1'b1;
        @(posedge clk); #1;
        a_reset = 1'b0;
        check("midrst_valid", {31'h0, a_ov}, 32'h0);
        check("midrst_data", {8'h0, a_od}, 32'h0);
        check("midrst_done", {31'h0, a_done}, 32'h0);
        @(negedge clk);
        sz = got_q.size();
        d0 = done_cnt;
        repeat (3) begin
            a_iv = 1'b1;
            a_id = 24'hFFFFFF;
            @(negedge clk);
        end
        a_iv = 1'b0;
        a_id = '0;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_no_output", got_q.size(), sz);
        check("midrst_no_done", done_cnt, d0);
        for (int i = 0; i < NP; i++) pix[i] = 24'($urandom);
        run_frame("post_reset", 1'b0, 2, 3, NOUT, 1);

        // Overflow: 8 back-to-back pixels into a 4-entry FIFO while the top border is still running.
`ifdef BORDER_PAD_OVERFLOW_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        @(negedge clk);
        c_reset = 1'b0;
        @(negedge clk);
        c_nf = 1'b1;
        @(negedge clk);
        c_nf = 1'b0;
        check("c_first_valid", {31'h0, c_ov}, 32'h1);
        check("c_first_zero", {8'h0, c_od}, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            c_iv = 1'b1;
            c_id = 24'(i);
            @(negedge clk);
            if (i == 4) check("c_ovf_at_full", {31'h0, c_ovf}, 32'h0);
            if (i == 5) check("c_ovf_first_drop", {31'h0, c_ovf}, {31'h0, exp_ovf});
        end
        c_iv = 1'b0;
        c_id = '0;
        repeat (4) @(negedge clk);
        check("c_ovf_sticky", {31'h0, c_ovf}, {31'h0, exp_ovf});
        check("c_no_done", {31'h0, c_done}, 32'h0);
        c_nf = 1'b1;
        @(negedge clk);
        c_nf = 1'b0;
        check("c_ovf_cleared", {31'h0, c_ovf}, 32'h0);
        c_reset = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/border_pad.md
BORDER_PAD -- requirements
Module: border_pad

Interface
REQ-001 SHALL have parameter width, default 320: active pixels per input row.
REQ-002 SHALL have parameter height, default 240: active rows per input frame.
REQ-003 SHALL have parameter fifoDepth, default 512: input FIFO entries, power of two, at least width+2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port newFrame, input, 1 bit: single-cycle start-of-frame strobe.
REQ-007 SHALL have port iValid, input, 1 bit: qualifies iData.
REQ-008 SHALL have port iData, input, 24 bits: demosaiced pixel {R[23:16], G[15:8], B[7:0]}, raster order.
REQ-009 SHALL have port oValid, output, 1 bit: qualifies oData, with no backpressure.
REQ-010 SHALL have port oData, output, 24 bits: padded pixel stream feeding the sharpen filter.
REQ-011 SHALL have port oDone, output, 1 bit: one-cycle pulse after the last padded pixel.
REQ-012 SHALL have port oOverflow, output, 1 bit: sticky FIFO-overflow flag.

Function
REQ-013 SHALL emit exactly (width+2)*(height+2) valid pixels per frame, in raster order, forming a one-pixel zero border (24'h0) around the width x height input image.
REQ-014 SHALL write input pixels to the FIFO only when iValid=1, the frame is armed, and the input count is below width*height.
- Pixels beyond width*height SHALL be ignored, including the trailing iValid used to flush upstream stages.
REQ-015 SHALL use FSM states IDLE, TOP, LEFT, PIX, RIGHT, BOTTOM, DONE.
REQ-016 In IDLE, newFrame SHALL cause these actions, then go to TOP on the next cycle:
- flush the FIFO;
- clear the input, column and row counters;
- arm input.
REQ-017 In TOP, the block SHALL emit one zero per cycle for width+2 cycles, then go to LEFT; input keeps filling the FIFO meanwhile.
REQ-018 In LEFT, the block SHALL emit one zero in a single cycle, then go to PIX.
REQ-019 In PIX:
- when the FIFO is non-empty, pop one entry and emit it with oValid=1;
- when the FIFO is empty, hold oValid=0 (gaps are legal);
- after width pops, go to RIGHT.
REQ-020 In RIGHT, the block SHALL emit one zero, increment the row counter, and go to LEFT if rows < height, else to BOTTOM.
REQ-021 In BOTTOM, the block SHALL emit width+2 zeros at one per cycle, then go to DONE.
REQ-022 In DONE, the block SHALL assert oDone for one cycle with oValid=0, disarm input, and return to IDLE.
REQ-023 Outputs SHALL be registered; the first oValid SHALL occur in the cycle after newFrame is sampled.
REQ-024 oData SHALL be 24'h0 whenever oValid=0.
REQ-025 A simultaneous FIFO write and read SHALL both take effect, leaving occupancy unchanged.
REQ-026 A write attempted while the FIFO is full SHALL be dropped and SHALL set oOverflow when REQ-033 applies.
REQ-027 newFrame in any non-IDLE state SHALL abort the current frame:
- flush the FIFO and clear the counters;
- go to TOP;
- do not pulse oDone.
REQ-028 When iValid and newFrame coincide, the pixel SHALL be counted as pixel 0 of the new frame, written after the flush.

Reset
REQ-029 reset SHALL have priority over newFrame and all other inputs.
REQ-030 While reset=1, the block SHALL hold:
- state IDLE;
- input disarmed;
- FIFO pointers and all counters at 0;
- oValid=0, oData=0, oDone=0, oOverflow=0.
REQ-031 Reset asserted mid-frame SHALL discard all buffered pixels; no further output is produced until the next newFrame.

Configuration
REQ-032 The macro BORDER_PAD_OVERFLOW_EN SHALL select whether FIFO-overflow detection is compiled in.
REQ-033 With BORDER_PAD_OVERFLOW_EN defined, oOverflow SHALL set on any dropped write and clear only on reset or newFrame.
REQ-034 Without BORDER_PAD_OVERFLOW_EN, oOverflow SHALL be tied to 0 and no detection logic is synthesized; the drop behaviour is unchanged.

Verification
REQ-035 width=4, height=2, newFrame, then 8 pixels 1..8 on consecutive cycles -> 24 oValid pixels equal to:
- 0 0 0 0 0 0
- 0 1 2 3 4 0
- 0 5 6 7 8 0
- 0 0 0 0 0 0
- then one oDone pulse.
REQ-036 Defaults, 320x240 stream with 16 idle cycles between rows and 32 cycles after newFrame -> 77924 outputs, zero border, interior equal to the input, oOverflow=0.
REQ-037 width=4, height=2, 8 pixels followed by 20 extra iValid cycles with data 0xFFFFFF -> no 0xFFFFFF appears on output; output count is 24.
REQ-038 newFrame asserted mid-PIX of row 0, followed by a full new frame -> no oDone from the aborted frame; the new frame's 24 outputs are correct.
REQ-039 fifoDepth=4, width=8, height=1, 8 back-to-back pixels -> oOverflow=1 with the macro defined and 0 without it.
REQ-040 reset asserted for 1 cycle at output pixel 10 -> next-cycle outputs are 0; the following frame is correct.
